change_dispenser: RTL and testbench
===================================

# change_dispenser

Downstream coin-payout stage of the vending controller. It accepts a change amount as two BCD digits (tens, units ∈ {0,5}) with a one-cycle start pulse. It then pays the amount out one coin at a time, 10-coins first and then at most one 5-coin. While each coin is paid, it drives the drop_money LED pattern for a fixed hold time, and it reports the remaining balance and a running paid-out total for the 7-segment display.

## Interface
- STEP_CYCLES, 4, cycles each coin's drop_money pattern is held (≥1)
- clk_select  in  1  clock, rising edge (already decided)
- rst  in  1  asynchronous, active-high reset (already decided)
- start  in  1  one-cycle request; sampled only in IDLE
- bcd_tens  in  4  change tens digit, valid 0..9
- bcd_units  in  4  change units digit, valid 0 or 5
- busy  out  1  high in CHECK and HOLD
- done  out  1  one-cycle pulse at end of a valid payout
- err  out  1  invalid request flag; sticky until next accepted start or rst
- coin_10  out  1  one-cycle pulse per 10-coin paid
- coin_5  out  1  one-cycle pulse per 5-coin paid
- drop_money  out  10  LED pattern: 10'h3FF for a 10-coin, 10'h3E0 for a 5-coin, 0 otherwise
- tens_left  out  4  remaining tens digit (BCD)
- units_left  out  4  remaining units digit (BCD)
- paid_out  out  7  binary total paid in the current transaction (max 95)

## Operation
- States: IDLE, CHECK, HOLD, DONE. All outputs are registered or decoded from the state register.
- Reset: state=IDLE; every output is 0, including the hold timer. This also applies mid-payout: the payout is abandoned with no done pulse, and drop_money clears immediately.
- IDLE, start=1, valid digits:
  - latch tens_left=bcd_tens, units_left=bcd_units
  - paid_out=0, err=0
  - go to CHECK
- IDLE, start=1, invalid digits (tens>9, or units∉{0,5}):
  - err=1; tens_left, units_left and paid_out are unchanged
  - stay in IDLE; no done pulse
- CHECK:
  - if tens_left>0: coin_10=1, drop_money=10'h3FF, tens_left−=1, paid_out+=10, timer=STEP_CYCLES−1, go to HOLD.
  - else if units_left==5: coin_5=1, drop_money=10'h3E0, units_left=0, paid_out+=5, timer=STEP_CYCLES−1, go to HOLD.
  - else: go to DONE.
- HOLD:
  - coin pulses return to 0 on the first HOLD edge.
  - if timer==0: drop_money=0, go to CHECK.
  - else: timer−=1.
- DONE: done=1 and busy=0 for exactly one cycle, then go to IDLE. tens_left, units_left and paid_out keep their final values until the next accepted start.
- start is ignored in CHECK, HOLD and DONE. There is no queueing.
- Amount 0 (tens=0, units=0) is valid: the sequence is CHECK→DONE with no coins.
- Arithmetic: the timer is clog2(STEP_CYCLES)+1 bits. tens_left never decrements below 0. paid_out never exceeds 95 for valid input.

## Timing
- Edge E0 samples start. From E0 to E1: state=CHECK, busy=1.
- The first coin is registered at E1. drop_money is non-zero for exactly STEP_CYCLES cycles.
- Coin period is STEP_CYCLES+1 cycles: STEP_CYCLES cycles of HOLD plus 1 cycle of CHECK.
- Total latency from start to done for N coins is N·(STEP_CYCLES+1)+2 edges.
  - Example, amount 25 with STEP_CYCLES=4: coins at E1 (10), E6 (10), E11 (5); CHECK at E16; done=1 at E17; IDLE at E18.
- busy falls on the same edge that done rises.
- err updates on the edge after the invalid start.

## Test plan
- Amount 25, STEP_CYCLES=4:
  - coin_10 pulses at E1 and E6, coin_5 at E11
  - drop_money=3FF for 4 cycles, then 0, then 3FF for 4 cycles, then 0, then 3E0 for 4 cycles
  - done at E17; paid_out=25; tens_left=0, units_left=0
- Amount 0: done pulses at E2; no coin pulses; drop_money stays 0; paid_out=0.
- Invalid request, bcd_units=3: err=1; state stays IDLE; no done. A subsequent valid start of 10 gives err=0 and one coin_10.
- start pulses during HOLD of a 95 payout are ignored:
  - exactly 9 coin_10 pulses and 1 coin_5 pulse
  - paid_out=95
  - done at 10·5+2=E52
- rst asserted mid-HOLD of the second coin: all outputs go to 0 asynchronously. After release, state is IDLE; there is no done pulse and no further coins.
- STEP_CYCLES=1, amount 15: coin_10 at E1, coin_5 at E3, done at E6.

Source files
------------

// File: rtl/change_dispenser.sv
// Coin-payout stage: pays a two-digit BCD change amount as 10-coins then at most one 5-coin,
// holding each coin's LED pattern for STEP_CYCLES cycles.
module change_dispenser #(
  parameter int STEP_CYCLES = 4
) (
  input  logic       clk_select,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] bcd_tens,
  input  logic [3:0] bcd_units,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       coin_10,
  output logic       coin_5,
  output logic [9:0] drop_money,
  output logic [3:0] tens_left,
  output logic [3:0] units_left,
  output logic [6:0] paid_out
);

  localparam int TW = $clog2(STEP_CYCLES) + 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CHECK, HOLD, DONE} state_t;

  state_t        state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic          err_nx, coin_10_nx, coin_5_nx;
  logic [9:0]    drop_money_nx;
  logic [3:0]    tens_left_nx, units_left_nx;
  logic [6:0]    paid_out_nx;
  logic          req_invalid;

  assign req_invalid = (bcd_tens > 4'd9) || ((bcd_units != 4'd0) && (bcd_units != 4'd5));

  always_ff @(posedge clk_select or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      err        <= 1'b0;
      coin_10    <= 1'b0;
      coin_5     <= 1'b0;
      drop_money <= '0;
      tens_left  <= '0;
      units_left <= '0;
      paid_out   <= '0;
    end else begin
      state      <= state_nx;
      timer      <= timer_nx;
      err        <= err_nx;
      coin_10    <= coin_10_nx;
      coin_5     <= coin_5_nx;
      drop_money <= drop_money_nx;
      tens_left  <= tens_left_nx;
      units_left <= units_left_nx;
      paid_out   <= paid_out_nx;
    end
  end

  // Coin pulses default low so they last exactly one cycle after the CHECK that issued them.
  always_comb begin
    state_nx      = state;
    timer_nx      = timer;
    err_nx        = err;
    coin_10_nx    = 1'b0;
    coin_5_nx     = 1'b0;
    drop_money_nx = drop_money;
    tens_left_nx  = tens_left;
    units_left_nx = units_left;
    paid_out_nx   = paid_out;
    case (state)
      IDLE: begin
        if (start) begin
          if (req_invalid) begin
            err_nx = 1'b1;
          end else begin
            err_nx        = 1'b0;
            tens_left_nx  = bcd_tens;
            units_left_nx = bcd_units;
            paid_out_nx   = 7'd0;
            state_nx      = CHECK;
          end
        end
      end
      CHECK: begin
        if (tens_left != 4'd0) begin
          coin_10_nx    = 1'b1;
          drop_money_nx = 10'h3FF;
          tens_left_nx  = tens_left - 4'd1;
          paid_out_nx   = paid_out + 7'd10;
          timer_nx      = TIMER_LOAD;
          state_nx      = HOLD;
        end else if (units_left == 4'd5) begin
          coin_5_nx     = 1'b1;
          drop_money_nx = 10'h3E0;
          units_left_nx = 4'd0;
          paid_out_nx   = paid_out + 7'd5;
          timer_nx      = TIMER_LOAD;
          state_nx      = HOLD;
        end else begin
          state_nx = DONE;
        end
      end
      HOLD: begin
        if (timer == '0) begin
          drop_money_nx = 10'h000;
          state_nx      = CHECK;
        end else begin
          timer_nx = timer - 1'b1;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == CHECK) || (state == HOLD);
  assign done = (state == DONE);

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: edge k means the k-th rising edge after the start-sampling edge E0;
// a DONE state seen just after edge k is reported as done at E(k+1).
module tb_change_dispenser;

  logic       clk_select = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] bcd_tens = 4'd0, bcd_units = 4'd0;
  logic       busy, done, err, coin_10, coin_5;
  logic [9:0] drop_money;
  logic [3:0] tens_left, units_left;
  logic [6:0] paid_out;

  logic       start1 = 1'b0;
  logic [3:0] bcd_tens1 = 4'd0, bcd_units1 = 4'd0;
  logic       busy1, done1, err1, coin_10_1, coin_5_1;
  logic [9:0] drop_money1;
  logic [3:0] tens_left1, units_left1;
  logic [6:0] paid_out1;

  int total = 0;
  int bad = 0;

  int n10, n5, done_cnt, done_k, c5_k;
  int c10_k [0:15];
  logic [9:0] drop_log [0:127];
  logic [9:0] drop_or;
  logic busy_e0, err_e0;

  always #5 clk_select = ~clk_select;

  change_dispenser #(.STEP_CYCLES(4)) u_dut (
    .clk_select(clk_select), .rst(rst), .start(start),
    .bcd_tens(bcd_tens), .bcd_units(bcd_units),
    .busy(busy), .done(done), .err(err), .coin_10(coin_10), .coin_5(coin_5),
    .drop_money(drop_money), .tens_left(tens_left), .units_left(units_left),
    .paid_out(paid_out)
  );

  change_dispenser #(.STEP_CYCLES(1)) u_dut1 (
    .clk_select(clk_select), .rst(rst), .start(start1),
    .bcd_tens(bcd_tens1), .bcd_units(bcd_units1),
    .busy(busy1), .done(done1), .err(err1), .coin_10(coin_10_1), .coin_5(coin_5_1),
    .drop_money(drop_money1), .tens_left(tens_left1), .units_left(units_left1),
    .paid_out(paid_out1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts a payout, then logs coin/done/drop activity for n_edges edges; optionally re-pulses start
  // after edge inject_k and asynchronously resets after edge rst_k.
  task automatic applyStimulus(input logic [3:0] t, input logic [3:0] u,
                               input int n_edges, input int inject_k, input int rst_k);
    n10 = 0; n5 = 0; done_cnt = 0; done_k = -1; c5_k = -1; drop_or = '0;
    for (int i = 0; i < 16; i++) c10_k[i] = -1;
    @(negedge clk_select);
    bcd_tens = t; bcd_units = u; start = 1'b1;
    @(posedge clk_select); #1;
    start = 1'b0;
    busy_e0 = busy;
    err_e0 = err;
    for (int k = 1; k <= n_edges; k++) begin
      @(posedge clk_select); #1;
      if (coin_10) begin
        if (n10 < 16) c10_k[n10] = k;
        n10++;
      end
      if (coin_5) begin
        n5++;
        c5_k = k;
      end
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (k < 128) drop_log[k] = drop_money;
      drop_or |= drop_money;
      start = (k == inject_k);
      if (k == rst_k) begin
        rst = 1'b1;
        #1;
        checkOutput("rst_drop", drop_money, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_coin10", coin_10, 0);
        checkOutput("rst_tens", tens_left, 0);
        checkOutput("rst_units", units_left, 0);
        checkOutput("rst_paid", paid_out, 0);
        @(negedge clk_select);
        rst = 1'b0;
      end
    end
  endtask

  initial begin
    int s1_c10, s1_c5, s1_done, idle_done;

    #1 rst = 1'b1;
    #2;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_err", err, 0);
    checkOutput("reset_drop", drop_money, 0);
    checkOutput("reset_paid", paid_out, 0);
    @(negedge clk_select);
    rst = 1'b0;

    $display("[TB] amount 25");
    applyStimulus(4'd2, 4'd5, 20, 0, 0);
    checkOutput("a25_busy_e0", busy_e0, 1);
    checkOutput("a25_n10", n10, 2);
    checkOutput("a25_n5", n5, 1);
    checkOutput("a25_c10_first", c10_k[0], 1);
    checkOutput("a25_c10_second", c10_k[1], 6);
    checkOutput("a25_c5", c5_k, 11);
    checkOutput("a25_drop1", drop_log[1], 10'h3FF);
    checkOutput("a25_drop4", drop_log[4], 10'h3FF);
    checkOutput("a25_drop5", drop_log[5], 10'h000);
    checkOutput("a25_drop6", drop_log[6], 10'h3FF);
    checkOutput("a25_drop10", drop_log[10], 10'h000);
    checkOutput("a25_drop11", drop_log[11], 10'h3E0);
    checkOutput("a25_drop14", drop_log[14], 10'h3E0);
    checkOutput("a25_drop15", drop_log[15], 10'h000);
    checkOutput("a25_done_edge", done_k + 1, 17);
    checkOutput("a25_done_cnt", done_cnt, 1);
    checkOutput("a25_paid", paid_out, 25);
    checkOutput("a25_tens", tens_left, 0);
    checkOutput("a25_units", units_left, 0);

    $display("[TB] invalid units digit");
    @(negedge clk_select);
    bcd_tens = 4'd1; bcd_units = 4'd3; start = 1'b1;
    @(posedge clk_select); #1;
    start = 1'b0;
    checkOutput("inv_err", err, 1);
    checkOutput("inv_busy", busy, 0);
    checkOutput("inv_paid_kept", paid_out, 25);
    idle_done = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk_select); #1;
      if (done || busy) idle_done++;
    end
    checkOutput("inv_stays_idle", idle_done, 0);
    checkOutput("inv_err_sticky", err, 1);

    applyStimulus(4'd1, 4'd0, 10, 0, 0);
    checkOutput("a10_err_cleared", err_e0, 0);
    checkOutput("a10_n10", n10, 1);
    checkOutput("a10_n5", n5, 0);
    checkOutput("a10_done_edge", done_k + 1, 7);
    checkOutput("a10_paid", paid_out, 10);

    $display("[TB] amount 0");
    applyStimulus(4'd0, 4'd0, 6, 0, 0);
    checkOutput("a0_coins", n10 + n5, 0);
    checkOutput("a0_drop", drop_or, 0);
    checkOutput("a0_done_edge", done_k + 1, 2);
    checkOutput("a0_paid", paid_out, 0);

    $display("[TB] amount 95 with ignored start");
    applyStimulus(4'd9, 4'd5, 56, 3, 0);
    checkOutput("a95_n10", n10, 9);
    checkOutput("a95_n5", n5, 1);
    checkOutput("a95_paid", paid_out, 95);
    checkOutput("a95_done_edge", done_k + 1, 52);
    checkOutput("a95_done_cnt", done_cnt, 1);

    $display("[TB] reset mid-hold");
    applyStimulus(4'd2, 4'd5, 30, 0, 7);
    checkOutput("rst_n10", n10, 2);
    checkOutput("rst_n5", n5, 0);
    checkOutput("rst_no_done", done_cnt, 0);
    checkOutput("rst_idle_busy", busy, 0);

    $display("[TB] STEP_CYCLES=1 amount 15");
    s1_c10 = -1; s1_c5 = -1; s1_done = -1;
    @(negedge clk_select);
    bcd_tens1 = 4'd1; bcd_units1 = 4'd5; start1 = 1'b1;
    @(posedge clk_select); #1;
    start1 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk_select); #1;
      if (coin_10_1 && s1_c10 < 0) s1_c10 = k;
      if (coin_5_1 && s1_c5 < 0) s1_c5 = k;
      if (done1 && s1_done < 0) s1_done = k;
    end
    checkOutput("s1_c10", s1_c10, 1);
    checkOutput("s1_c5", s1_c5, 3);
    checkOutput("s1_done_edge", s1_done + 1, 6);
    checkOutput("s1_paid", paid_out1, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
